// File: rtl/secded_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : secded_link_pkg
//  Description : Shared definitions for the SECDED(8,4) link modem:
//                codeword bit positions, lane codeword / syndrome types and
//                the per-lane encode function.
//  Revision    : 1.0 - initial release
// ============================================================================
package secded_link_pkg;

  localparam int unsigned LANE_DW = 4;
  localparam int unsigned LANE_CW = 8;

  // Codeword bit positions within one lane (Hamming positions 1..7, then P0)
  localparam int unsigned POS_P1 = 0;
  localparam int unsigned POS_P2 = 1;
  localparam int unsigned POS_D0 = 2;
  localparam int unsigned POS_P4 = 3;
  localparam int unsigned POS_D1 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D3 = 6;
  localparam int unsigned POS_P0 = 7;

  typedef logic [LANE_CW-1:0] lane_code_t;
  typedef logic [2:0]         lane_syn_t;

  // Build one 8-bit lane codeword from a 4-bit nibble
  function automatic lane_code_t encode_lane(input logic [LANE_DW-1:0] d);
    lane_code_t c;
    c         = '0;
    c[POS_D0] = d[0];
    c[POS_D1] = d[1];
    c[POS_D2] = d[2];
    c[POS_D3] = d[3];
    c[POS_P1] = d[0] ^ d[1] ^ d[3];
    c[POS_P2] = d[0] ^ d[2] ^ d[3];
    c[POS_P4] = d[1] ^ d[2] ^ d[3];
    // Overall parity covers the seven Hamming bits so the full word has even parity
    c[POS_P0] = ^c[POS_D3:POS_P1];
    return c;
  endfunction

endpackage : secded_link_pkg
`default_nettype wire

// File: rtl/secded84_lane_dec.sv
`default_nettype none
// ============================================================================
//  Module      : secded84_lane_dec
//  Description : Combinational SECDED(8,4) decoder for a single lane.
//                Corrects any single-bit error (including the overall parity
//                bit) and flags double-bit errors without touching the data.
//  Revision    : 1.0 - initial release
// ============================================================================
module secded84_lane_dec
  import secded_link_pkg::*;
(
  input  logic [LANE_CW-1:0] code,
  output logic [LANE_DW-1:0] data,
  output logic               corr,
  output logic               uncorr
);

  lane_syn_t  syn;
  logic       par;
  logic [2:0] flip_pos;
  lane_code_t fixed;

  // Syndrome, overall parity and single-bit repair of the received word
  always_comb begin
    syn[0]   = code[POS_P1] ^ code[POS_D0] ^ code[POS_D1] ^ code[POS_D3];
    syn[1]   = code[POS_P2] ^ code[POS_D0] ^ code[POS_D2] ^ code[POS_D3];
    syn[2]   = code[POS_P4] ^ code[POS_D1] ^ code[POS_D2] ^ code[POS_D3];
    par      = ^code;
    // Syndrome s points at bit s-1; s=0 with bad parity means P0 itself,
    // which is exactly where the 3-bit wrap of 0-1 lands (bit 7).
    flip_pos = syn - 3'd1;
    fixed    = code;
    corr     = 1'b0;
    uncorr   = 1'b0;
    if (par) begin
      corr            = 1'b1;
      fixed[flip_pos] = ~code[flip_pos];
    end else if (syn != 3'd0) begin
      uncorr = 1'b1;
    end
    data = {fixed[POS_D3], fixed[POS_D2], fixed[POS_D1], fixed[POS_D0]};
  end

endmodule : secded84_lane_dec
`default_nettype wire

// File: rtl/secded_link_modem.sv
`default_nettype none
// ============================================================================
//  Module      : secded_link_modem
//  Description : Three-stage SECDED(8,4) link modem. Stage 1 encodes the
//                payload per 4-bit lane, stage 2 selects the received word
//                (internal loopback with error injection, or rx_code),
//                stage 3 registers decoded data, per-lane flags and LEDs.
//                Optional macro SECDED_LINK_ERRCNT_EN adds saturating
//                corrected / uncorrectable frame counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module secded_link_modem
  import secded_link_pkg::*;
#(
  parameter int NLANE = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk_slow,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [4*NLANE-1:0] in_data,
  input  logic [8*NLANE-1:0] err_mask,
  input  logic               loopback,
  input  logic [8*NLANE-1:0] rx_code,
  input  logic               cnt_clr,
  output logic [8*NLANE-1:0] tx_code,
  output logic               tx_valid,
  output logic               out_valid,
  output logic [4*NLANE-1:0] out_data,
  output logic [NLANE-1:0]   corr_flag,
  output logic [NLANE-1:0]   uncorr_flag,
  output logic [CNT_W-1:0]   corr_cnt,
  output logic [CNT_W-1:0]   uncorr_cnt,
  output logic [7:0]         led_1,
  output logic [7:0]         led_2
);

  // Stage 1
  logic               s1_valid_q,  s1_valid_d;
  logic [8*NLANE-1:0] tx_code_q,   tx_code_d;
  logic [8*NLANE-1:0] s1_mask_q,   s1_mask_d;
  logic [4*NLANE-1:0] s1_data_q,   s1_data_d;
  // Stage 2
  logic               s2_valid_q,  s2_valid_d;
  logic [8*NLANE-1:0] s2_rx_q,     s2_rx_d;
  logic [4*NLANE-1:0] s2_data_q,   s2_data_d;
  // Stage 3
  logic               out_valid_q, out_valid_d;
  logic [4*NLANE-1:0] out_data_q,  out_data_d;
  logic [NLANE-1:0]   corr_q,      corr_d;
  logic [NLANE-1:0]   uncorr_q,    uncorr_d;
  logic [7:0]         led_1_q,     led_1_d;
  logic [7:0]         led_2_q,     led_2_d;

  logic [4*NLANE-1:0] w_dec_data;
  logic [NLANE-1:0]   w_dec_corr;
  logic [NLANE-1:0]   w_dec_uncorr;

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    secded84_lane_dec u_dec (
      .code   (s2_rx_q[8*k +: 8]),
      .data   (w_dec_data[4*k +: 4]),
      .corr   (w_dec_corr[k]),
      .uncorr (w_dec_uncorr[k])
    );
  end

  // Next-state for all three pipeline stages
  always_comb begin
    s1_valid_d = in_valid;
    s1_mask_d  = err_mask;
    s1_data_d  = in_data;
    tx_code_d  = '0;
    for (int k = 0; k < NLANE; k++) begin
      tx_code_d[8*k +: 8] = encode_lane(in_data[4*k +: 4]);
    end

    s2_valid_d = s1_valid_q;
    s2_rx_d    = loopback ? (tx_code_q ^ s1_mask_q) : rx_code;
    s2_data_d  = s1_data_q;

    // Flags are forced low on idle cycles; data and LEDs hold the last frame
    out_valid_d = s2_valid_q;
    out_data_d  = out_data_q;
    corr_d      = '0;
    uncorr_d    = '0;
    led_1_d     = led_1_q;
    led_2_d     = led_2_q;
    if (s2_valid_q) begin
      out_data_d = w_dec_data;
      corr_d     = w_dec_corr;
      uncorr_d   = w_dec_uncorr;
      led_1_d    = s2_rx_q[7:0];
      led_2_d    = {s2_data_q[3:0], w_dec_data[3:0]};
    end
  end

  // Pipeline registers; reset discards any frame in flight
  always_ff @(posedge clk_slow or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      tx_code_q   <= '0;
      s1_mask_q   <= '0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_rx_q     <= '0;
      s2_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      corr_q      <= '0;
      uncorr_q    <= '0;
      led_1_q     <= '0;
      led_2_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      tx_code_q   <= tx_code_d;
      s1_mask_q   <= s1_mask_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_rx_q     <= s2_rx_d;
      s2_data_q   <= s2_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      corr_q      <= corr_d;
      uncorr_q    <= uncorr_d;
      led_1_q     <= led_1_d;
      led_2_q     <= led_2_d;
    end
  end

  assign tx_code     = tx_code_q;
  assign tx_valid    = s1_valid_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign corr_flag   = corr_q;
  assign uncorr_flag = uncorr_q;
  assign led_1       = led_1_q;
  assign led_2       = led_2_q;

`ifdef SECDED_LINK_ERRCNT_EN
  logic [CNT_W-1:0] corr_cnt_q,   corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  // Saturating per-frame error counters; a clear beats a same-cycle increment
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (s2_valid_q) begin
      if ((|w_dec_corr) && (corr_cnt_q != {CNT_W{1'b1}})) begin
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      end
      if ((|w_dec_uncorr) && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_slow or negedge reset) begin
    if (!reset) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule : secded_link_modem
`default_nettype wire

// File: tb/tb_secded_link_modem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_secded_link_modem
//  Description : Directed self-checking bench for secded_link_modem
//                (NLANE=2, CNT_W=8). Counter expectations follow whether
//                SECDED_LINK_ERRCNT_EN is defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_secded_link_modem;

`ifdef SECDED_LINK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_slow = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [15:0] err_mask;
  logic        loopback;
  logic [15:0] rx_code;
  logic        cnt_clr;
  logic [15:0] tx_code;
  logic        tx_valid;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  corr_flag;
  logic [1:0]  uncorr_flag;
  logic [7:0]  corr_cnt;
  logic [7:0]  uncorr_cnt;
  logic [7:0]  led_1;
  logic [7:0]  led_2;

  int n_total = 0;
  int n_bad   = 0;
  int m_corr  = 0;
  int m_uncorr = 0;

  secded_link_modem #(.NLANE(2), .CNT_W(8)) u_dut (
    .clk_slow    (clk_slow),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .err_mask    (err_mask),
    .loopback    (loopback),
    .rx_code     (rx_code),
    .cnt_clr     (cnt_clr),
    .tx_code     (tx_code),
    .tx_valid    (tx_valid),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .corr_flag   (corr_flag),
    .uncorr_flag (uncorr_flag),
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt),
    .led_1       (led_1),
    .led_2       (led_2)
  );

  always #5 clk_slow = ~clk_slow;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge
  task automatic step();
    @(posedge clk_slow);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [7:0] exp_cnt(input int v);
    return CNT_EN ? v[7:0] : 8'h00;
  endfunction

  // Push one isolated frame through loopback and check the decoded result
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [15:0] m,
                           input logic [1:0] exp_c, input logic [1:0] exp_u,
                           input logic [7:0] exp_led1);
    in_valid = 1'b1; in_data = d; err_mask = m;
    step();
    in_valid = 1'b0; err_mask = 16'h0000;
    step();
    step();
    if (|exp_c) m_corr   = sat(m_corr + 1);
    if (|exp_u) m_uncorr = sat(m_uncorr + 1);
    check({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
    check({tag, ".data"},   {24'd0, out_data}, {24'd0, d});
    check({tag, ".corr"},   {30'd0, corr_flag}, {30'd0, exp_c});
    check({tag, ".uncorr"}, {30'd0, uncorr_flag}, {30'd0, exp_u});
    check({tag, ".led1"},   {24'd0, led_1}, {24'd0, exp_led1});
    check({tag, ".led2"},   {24'd0, led_2}, {24'd0, d[3:0], d[3:0]});
    check({tag, ".ccnt"},   {24'd0, corr_cnt}, {24'd0, exp_cnt(m_corr)});
    check({tag, ".ucnt"},   {24'd0, uncorr_cnt}, {24'd0, exp_cnt(m_uncorr)});
    step();
    check({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".idle_flags"}, {28'd0, corr_flag, uncorr_flag}, 32'd0);
    check({tag, ".led1_hold"},  {24'd0, led_1}, {24'd0, exp_led1});
  endtask

  initial begin
    int seen;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; err_mask = 16'h0000;
    loopback = 1'b1; rx_code = 16'h0000; cnt_clr = 1'b0;
    #23;
    check("rst.outs", {tx_valid, out_valid, corr_flag, uncorr_flag}, 32'd0);
    check("rst.code", {tx_code, led_1, led_2}, 32'd0);
    check("rst.cnt",  {16'd0, corr_cnt, uncorr_cnt}, 32'd0);
    reset = 1'b1;
    step();

    // Encode: FB -> FF55 one cycle later
    in_valid = 1'b1; in_data = 8'hFB; err_mask = 16'h0000;
    step();
    check("enc.tx_code",  {16'd0, tx_code}, 32'h0000_FF55);
    check("enc.tx_valid", {31'd0, tx_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check("enc.no_early", {31'd0, out_valid}, 32'd0);
    step();
    check("enc.valid", {31'd0, out_valid}, 32'd1);
    check("enc.data",  {24'd0, out_data}, 32'h0000_00FB);
    check("enc.flags", {28'd0, corr_flag, uncorr_flag}, 32'd0);
    check("enc.led",   {16'd0, led_1, led_2}, 32'h0000_55BB);
    step();

    // Single data-bit error on lane 0, double error on lane 1, parity-bit error
    run_frame("sec",  8'h0B, 16'h0010, 2'b01, 2'b00, 8'h45);
    run_frame("ded",  8'h0B, 16'h0300, 2'b00, 2'b10, 8'h55);
    run_frame("par",  8'h0B, 16'h8000, 2'b10, 2'b00, 8'h55);
    run_frame("p0l0", 8'hA6, 16'h0080, 2'b01, 2'b00, 8'hB3);

    // Back-to-back frames every cycle
    in_valid = 1'b1; in_data = 8'h12; step();
    in_data = 8'h34; step();
    in_data = 8'h56; step();
    check("b2b.d0", {23'd0, out_valid, out_data}, 32'h0000_0112);
    in_valid = 1'b0; step();
    check("b2b.d1", {23'd0, out_valid, out_data}, 32'h0000_0134);
    step();
    check("b2b.d2", {23'd0, out_valid, out_data}, 32'h0000_0156);
    step();
    check("b2b.hold", {23'd0, out_valid, led_1}, 32'h0000_0033);
    check("b2b.led2", {24'd0, led_2}, 32'h0000_0066);

    // 300 corrected frames: counter saturates
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = i[7:0]; err_mask = 16'h0001;
      step();
    end
    in_valid = 1'b0; err_mask = 16'h0000;
    step(); step(); step();
    m_corr = sat(m_corr + 300);
    check("sat.ccnt", {24'd0, corr_cnt}, {24'd0, exp_cnt(m_corr)});
    check("sat.ucnt", {24'd0, uncorr_cnt}, {24'd0, exp_cnt(m_uncorr)});

    // Clear coincident with a flagged frame leaving stage 3
    in_valid = 1'b1; in_data = 8'h5A; err_mask = 16'h0001;
    step(); step();
    cnt_clr = 1'b1;
    step();
    check("clr.frame", {29'd0, out_valid, corr_flag}, 32'd5);
    check("clr.cnt",   {16'd0, corr_cnt, uncorr_cnt}, 32'd0);
    cnt_clr = 1'b0; in_valid = 1'b0; err_mask = 16'h0000;
    step(); step(); step();
    m_corr = 2; m_uncorr = 0;
    check("clr.after", {24'd0, corr_cnt}, {24'd0, exp_cnt(m_corr)});

    // Reset with three frames in flight
    in_valid = 1'b1; in_data = 8'hC3; err_mask = 16'h0010;
    step(); step(); step();
    #3;
    reset = 1'b0; in_valid = 1'b0; err_mask = 16'h0000;
    #1;
    check("mrst.outs", {tx_valid, out_valid, corr_flag, uncorr_flag, out_data}, 32'd0);
    check("mrst.code", {tx_code, led_1, led_2}, 32'd0);
    check("mrst.cnt",  {16'd0, corr_cnt, uncorr_cnt}, 32'd0);
    #7;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("mrst.stale", seen, 0);

    // External receive path: rx_code 55FF decodes to BF
    loopback = 1'b0; rx_code = 16'h55FF;
    in_valid = 1'b1; in_data = 8'h00;
    step();
    in_valid = 1'b0;
    check("rx.lat1", {31'd0, out_valid}, 32'd0);
    step();
    check("rx.lat2", {31'd0, out_valid}, 32'd0);
    step();
    check("rx.valid", {31'd0, out_valid}, 32'd1);
    check("rx.data",  {24'd0, out_data}, 32'h0000_00BF);
    check("rx.flags", {28'd0, corr_flag, uncorr_flag}, 32'd0);
    check("rx.led",   {16'd0, led_1, led_2}, 32'h0000_FF0F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_secded_link_modem
`default_nettype wire

// File: doc/secded_link_modem.md
SECDED_LINK_MODEM -- requirements
Module: secded_link_modem

Interface
REQ-001 SHALL have parameter NLANE, default 2: number of independent 4-bit lanes; data width 4*NLANE, codeword width 8*NLANE.
REQ-002 SHALL have parameter CNT_W, default 8: width of each error counter.
REQ-003 SHALL have ports, in this order:
- clk_slow  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  frame present on in_data.
- in_data  in  4*NLANE  payload; lane k is bits [4k+3:4k].
- err_mask  in  8*NLANE  error-injection XOR mask, sampled with in_data.
- loopback  in  1  1 = internal loopback, 0 = use rx_code.
- rx_code  in  8*NLANE  codeword from A/D.
- cnt_clr  in  1  synchronous counter clear.
- tx_code  out  8*NLANE  codeword to D/A.
- tx_valid  out  1  tx_code valid.
- out_valid  out  1  decoded frame valid.
- out_data  out  4*NLANE  decoded payload.
- corr_flag  out  NLANE  per-lane single error corrected.
- uncorr_flag  out  NLANE  per-lane double error detected.
- corr_cnt  out  CNT_W  frames with at least one corrected lane.
- uncorr_cnt  out  CNT_W  frames with at least one uncorrectable lane.
- led_1  out  8  lane-0 received codeword.
- led_2  out  8  {lane-0 original nibble, lane-0 decoded nibble}.

Function
REQ-004 Lane codeword: b0=p1, b1=p2, b2=d0, b3=p4, b4=d1, b5=d2, b6=d3, b7=p0; p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3, p0=XOR(b6..b0).
REQ-005 Stage 1 SHALL register tx_code=encode(in_data), tx_valid=in_valid, and carry err_mask and in_data.
REQ-006 Stage 2 SHALL register rx word = loopback ? (tx_code ^ carried err_mask) : rx_code; loopback is sampled in this stage.
REQ-007 Stage 3 SHALL register decode results; out_valid SHALL rise exactly 3 cycles after in_valid; back-to-back frames SHALL be accepted every cycle.
REQ-008 Decode per lane: s={s4,s2,s1} Hamming syndrome, P=XOR of all 8 bits.
- s=0, P=0: clean.
- P=1: single error; flip bit s-1 (s=0: bit 7); corr_flag=1.
- s!=0, P=0: uncorr_flag=1; data passed uncorrected.
REQ-009 Flags and out_data SHALL be meaningful only when out_valid=1; with out_valid=0, flags SHALL be 0.
REQ-010 Counters SHALL increment by 1 per valid frame with any flag set, saturate at all-ones, and never wrap.
REQ-011 cnt_clr SHALL zero both counters next cycle; clear SHALL win over a simultaneous increment.
REQ-012 led_1 and led_2 SHALL update only on out_valid and hold between frames.
REQ-013 Changing loopback mid-stream SHALL affect only frames entering stage 2 after the change.

Reset
REQ-014 reset low SHALL asynchronously clear all pipeline registers, all outputs, and both counters to 0.
REQ-015 Frames in flight at reset SHALL be discarded; there SHALL be no out_valid until 3 cycles after the first post-reset in_valid.

Configuration
REQ-016 With macro SECDED_LINK_ERRCNT_EN defined, the counters SHALL be implemented per REQ-010/011.
REQ-017 Without SECDED_LINK_ERRCNT_EN, corr_cnt and uncorr_cnt SHALL be tied to 0, cnt_clr SHALL be ignored, and no counter flops SHALL be inferred.

Structure
REQ-018 Package secded_link_pkg SHALL hold the codeword bit-position constants, the lane codeword/syndrome typedefs, and the encode function.
REQ-019 The per-lane combinational decoder SHALL be sub-module secded84_lane_dec, instantiated NLANE times with a generate loop.

Verification
REQ-020 Encode check: NLANE=2, in_data=8'hFB, loopback=1, err_mask=0 -> tx_code=16'hFF55 one cycle later; out_data=8'hFB three cycles later; no flags.
REQ-021 Single-error correction: in_data=8'h0B, err_mask=16'h0010 -> out_data=8'h0B, corr_flag=2'b01, corr_cnt increments by 1.
REQ-022 Double-error detection: err_mask=16'h0300 on lane 1 -> uncorr_flag=2'b10, uncorr_cnt increments by 1, corr_cnt unchanged.
REQ-023 Parity-bit error: err_mask=16'h8000 -> corr_flag=2'b10, data intact.
REQ-024 Counter limits: 300 corrected frames with CNT_W=8 -> corr_cnt holds at 8'hFF; cnt_clr coincident with a flagged frame -> 0.
REQ-025 Reset mid-stream: reset low with 3 frames in flight -> all outputs 0 immediately, no stale out_valid after release; loopback=0, rx_code=16'h55FF -> out_data=8'hBF.
